// File: rtl/mdu_iter.sv
// Iterative signed multiply/divide unit: one radix-2 step per clock on operand
// magnitudes, sign applied once when the final result is registered.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             stall
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    COUNT_ONE  = CW'(1);
    localparam logic [CW-1:0]    COUNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [CW-1:0]      count_r;
    logic               op_div_r;
    logic               sign_r;
    logic [WIDTH-1:0]   operand_r;     // multiplicand for mult, divisor for div
    logic [2*WIDTH-1:0] prod_r;        // {accumulator/remainder, multiplier/quotient}
    logic               accept_s;
    logic               last_s;
    logic [WIDTH:0]     mult_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_diff_s;
    logic [2*WIDTH-1:0] prod_next_s;
    logic [WIDTH-1:0]   final_s;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            magnitude = ~v + ONE;
        end else begin
            magnitude = v;
        end
    endfunction

    assign accept_s = (state_r == IDLE) && start && !cancel;
    assign last_s   = (count_r == COUNT_LAST);

    // One shift-add or restoring shift-subtract step, plus the signed final value
    always_comb begin
        mult_sum_s  = {1'b0, prod_r[2*WIDTH-1:WIDTH]}
                    + (prod_r[0] ? {1'b0, operand_r} : {(WIDTH+1){1'b0}});
        div_shift_s = {prod_r[2*WIDTH-1:WIDTH], prod_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, operand_r};
        if (op_div_r) begin
            if (!div_diff_s[WIDTH]) begin
                prod_next_s = {div_diff_s[WIDTH-1:0], prod_r[WIDTH-2:0], 1'b1};
            end else begin
                prod_next_s = {div_shift_s[WIDTH-1:0], prod_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            prod_next_s = {mult_sum_s, prod_r[WIDTH-1:1]};
        end
        // Divide by zero saturates to all ones irrespective of operand signs
        if (op_div_r && (operand_r == {WIDTH{1'b0}})) begin
            final_s = {WIDTH{1'b1}};
        end else if (sign_r) begin
            final_s = ~prod_next_s[WIDTH-1:0] + ONE;
        end else begin
            final_s = prod_next_s[WIDTH-1:0];
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (cancel) begin
                    state_s = IDLE;
                end else if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        stall = accept_s;
        case (state_r)
            IDLE: begin
                busy = 1'b0;
            end
            RUN: begin
                busy  = 1'b1;
                stall = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = !cancel;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Operand capture, iteration datapath and result register
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r   <= {CW{1'b0}};
            op_div_r  <= 1'b0;
            sign_r    <= 1'b0;
            operand_r <= {WIDTH{1'b0}};
            prod_r    <= {(2*WIDTH){1'b0}};
            result    <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            count_r   <= {CW{1'b0}};
            op_div_r  <= op_div;
            sign_r    <= a[WIDTH-1] ^ b[WIDTH-1];
            operand_r <= op_div ? magnitude(b) : magnitude(a);
            prod_r    <= {{WIDTH{1'b0}}, (op_div ? magnitude(a) : magnitude(b))};
        end else if ((state_r == RUN) && !cancel) begin
            count_r <= count_r + COUNT_ONE;
            prod_r  <= prod_next_s;
            if (last_s) begin
                result <= final_s;
            end
        end
    end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative signed multiply/divide unit in the EXE stage of the pipeline CPU.
- Consumes decoded `mult`/`div` ops from the control unit: aluc 4'b1011 is mult, 4'b1010 is div. Decode to `op_div` happens upstream.
- Returns a WIDTH-bit result that is written to rd, like any ALU result.
- Holds the pipeline via `stall` while an operation is in flight.

Parameters:
- WIDTH, 32, operand/result width; also the number of iterations per operation.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; sampled only in IDLE.
- op_div  in  1  0 = mult (low WIDTH bits of signed product); 1 = div (signed quotient).
- a  in  WIDTH  rs operand, captured at start.
- b  in  WIDTH  rt operand, captured at start.
- cancel  in  1  pipeline flush; aborts the in-flight operation.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; result valid this cycle.
- result  out  WIDTH  registered result; holds until the next done.
- stall  out  1  combinational pipeline hold: (IDLE & start & ~cancel) | RUN.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, result=0, count=0, internal operand/accumulator registers=0. Reset wins over start and cancel in the same cycle. Reset mid-operation returns to IDLE with no done.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on edge with start & ~cancel. At that edge:
  - latch |a|, |b|, op_div, and sign: a[MSB]^b[MSB] for both mult and div.
  - count=0; clear accumulator.
- RUN: one radix-2 iteration per edge, count+1.
  - mult: shift-add on magnitudes, 2*WIDTH-bit product register.
  - div: restoring shift-subtract on magnitudes, WIDTH-bit remainder.
  - After iteration WIDTH-1 (count==WIDTH-1): go to DONE and register the final result.
- Final result:
  - mult: magnitude product low WIDTH bits, two's-complement negated if sign=1. This equals the low WIDTH bits of the true signed product.
  - div: magnitude quotient, negated if sign=1, truncated toward zero; remainder discarded.
  - div by zero: result = all ones (32'hFFFFFFFF), regardless of sign. Latency unchanged; no early exit.
  - Overflow case (-2^(WIDTH-1)) / -1: result = 32'h80000000 (wraps naturally); no trap.
- DONE: done=1 for exactly this cycle, stall=0 so the pipeline advances with the result. Next edge -> IDLE unconditionally.
- Latency: start sampled at edge E. RUN occupies the WIDTH cycles after E. done=1 in cycle E+WIDTH+1 (cycle 33 for WIDTH=32, counting the start cycle as 0).
- start while RUN or DONE: ignored, never queued. Upstream keeps start asserted while stall=1, so re-issue occurs naturally.
- start in the same cycle as DONE is ignored. It is accepted in the following IDLE cycle.
- cancel:
  - In RUN or DONE: next edge -> IDLE, done forced 0 that cycle, result keeps its previous value.
  - In IDLE: suppresses acceptance of start.
- result changes only at the RUN->DONE edge; stable otherwise, including through cancel.
- count width = clog2(WIDTH); no wrap occurs since RUN exits at WIDTH-1.
- Operands a/b may change after acceptance without effect.

Test Plan:
1. Reset, then start with op_div=0, a=7, b=-3 (0xFFFFFFFD) -> stall=1 cycles 0..32, done=1 only in cycle 33, result=0xFFFFFFEB, stall=0 in cycle 33.
2. div a=-100 (0xFFFFFF9C), b=7 -> result=0xFFFFFFF2 (-14) at cycle 33. Then div a=100, b=-7 -> 0xFFFFFFF2. Then mult a=0x00010000, b=0x00010000 -> 0x00000000 (low bits).
3. div by zero a=5, b=0 -> result=0xFFFFFFFF at cycle 33. div a=0x80000000, b=0xFFFFFFFF -> 0x80000000.
4. Issue mult 6*7; pulse start with different operands at cycles 5 and 33 -> exactly one done at cycle 33 with result=42. A new op is accepted at cycle 34 only if start is high then.
5. Cancel at cycle 10 of a div -> busy=0 from cycle 11, no done pulse, result still holds the prior value (42). A new start at cycle 11 completes normally 33 cycles later.
6. Reset asserted at cycle 20 of a mult -> cycle 21: busy=0, done=0, result=0, stall=0 with start low; a subsequent op runs with the full 33-cycle latency.
